lut_ram_reader: RTL and testbench
=================================

LUT_RAM_READER -- requirements
Module: lut_ram_reader

Interface
REQ-001 Parameter W, default 32: data word width in bits.
REQ-002 Parameter D, default 16384: RAM depth in words; AW = $clog2(D) is the address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle command strobe, sampled only in IDLE.
REQ-006 base_addr  input  AW  first RAM address of the burst, sampled with start.
REQ-007 length  input  AW+1  number of words to stream, sampled with start.
REQ-008 ram_read_addr  output  AW  read address to the LUT RAM (combinational read port).
REQ-009 ram_data  input  W  RAM read data, valid in the same cycle as ram_read_addr.
REQ-010 m_data  output  W  registered stream data.
REQ-011 m_valid  output  1  m_data holds a word not yet accepted.
REQ-012 m_ready  input  1  downstream accepts m_data when high together with m_valid.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse after the last word of a burst is accepted.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, STREAM; busy SHALL equal (state != IDLE).
REQ-016 ram_read_addr SHALL be driven directly from the internal address register.
REQ-017 IDLE, start=1, length>0: SHALL load addr<=base_addr, remaining<=min(length, D), go to FETCH.
REQ-018 IDLE, start=1, length=0: SHALL stay IDLE and pulse done in the next cycle; m_valid stays 0.
REQ-019 start while busy SHALL be ignored with no effect on the burst in progress.
REQ-020 FETCH: SHALL capture m_data<=ram_data, set m_valid<=1, addr<=addr+1, remaining<=remaining-1, go to STREAM; first m_valid therefore rises on the second edge after start is sampled.
REQ-021 STREAM, handshake (m_valid & m_ready) with remaining>0: SHALL capture next ram_data, addr++, remaining--, keep m_valid=1; one word per cycle sustained.
REQ-022 STREAM, handshake with remaining=0: SHALL clear m_valid, pulse done, return to IDLE.
REQ-023 STREAM, m_valid=1 and m_ready=0: m_data, m_valid, addr, remaining SHALL hold.
REQ-024 Address arithmetic SHALL be modulo D: D-1 increments to 0.
REQ-025 length > D SHALL be clamped to D words (each address read exactly once).
REQ-026 m_data SHALL retain the last streamed value after the burst; only m_valid clears.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, addr=0, remaining=0, m_data=0, m_valid=0, done=0, busy=0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-029 Macro LUT_RAM_READER_ABORT_EN SHALL, when defined, add input abort (1 bit); abort=1 while busy SHALL on the next edge clear m_valid, return to IDLE and pulse done; abort in IDLE SHALL be ignored; abort has priority over a simultaneous handshake.
REQ-030 Without LUT_RAM_READER_ABORT_EN the abort port SHALL not exist and bursts SHALL run only to completion or reset.

Verification
REQ-031 RAM preloaded addr 2=32'hDEADBEEF, 3=32'hCAFEBABE; start base=2 length=2, m_ready=1 -> m_data DEADBEEF then CAFEBABE on consecutive cycles, done one cycle after second accept, busy low after.
REQ-032 Same burst with m_ready low for 3 cycles on first word -> m_data holds DEADBEEF, ram_read_addr holds 3, no word lost or duplicated.
REQ-033 base=16383 length=3 -> words from addresses 16383, 0, 1 in order.
REQ-034 start length=0 -> no m_valid, done pulse next cycle; start asserted mid-burst -> ignored.
REQ-035 rst_n low during STREAM after 1 of 4 words (addr 368) -> all outputs 0 asynchronously, no done; new burst base=368 length=1 returns 32'h12345678.
REQ-036 With LUT_RAM_READER_ABORT_EN: abort on second word of a 4-word burst -> m_valid 0 and done pulse next cycle, state IDLE.

Source files
------------

// File: rtl/lut_ram_reader.sv
// Streams a burst of consecutive words from a combinational-read LUT RAM onto a ready/valid port.
// Optional macro LUT_RAM_READER_ABORT_EN adds an abort input that cancels a burst in progress.
module lut_ram_reader #(
  parameter int W = 32,
  parameter int D = 16384,
  localparam int AW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic [AW-1:0] ram_read_addr,
  input  logic [W-1:0]  ram_data,
  output logic [W-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
`ifdef LUT_RAM_READER_ABORT_EN
  ,
  input  logic          abort
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  localparam logic [AW:0]   DEPTH_LEN = (AW + 1)'(D);
  localparam logic [AW-1:0] LAST_ADDR = AW'(D - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [W-1:0]  m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          done_q, done_d;

  logic [AW-1:0] addr_inc;
  logic [AW:0]   len_clamped;
  logic          handshake;
  logic          abort_req;

  // Wrap explicitly so non-power-of-two depths still cycle through 0..D-1.
  assign addr_inc    = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  assign len_clamped = (length > DEPTH_LEN) ? DEPTH_LEN : length;
  assign handshake   = m_valid_q & m_ready;

`ifdef LUT_RAM_READER_ABORT_EN
  assign abort_req = abort & (state_q != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = base_addr;
            remaining_d = len_clamped;
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        m_data_d    = ram_data;
        m_valid_d   = 1'b1;
        addr_d      = addr_inc;
        remaining_d = remaining_q - 1'b1;
        state_d     = STREAM;
      end
      STREAM: begin
        if (handshake) begin
          if (remaining_q != '0) begin
            m_data_d    = ram_data;
            addr_d      = addr_inc;
            remaining_d = remaining_q - 1'b1;
          end else begin
            m_valid_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
      end
    endcase

    // Abort wins over any handshake landing on the same edge.
    if (abort_req) begin
      m_valid_d   = 1'b0;
      remaining_d = '0;
      done_d      = 1'b1;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      done_q      <= done_d;
    end
  end

  assign ram_read_addr = addr_q;
  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_lut_ram_reader.sv
// Bench for lut_ram_reader: table of bursts plus random bursts checked against an array RAM model,
// with hand sequences for backpressure, zero length, mid-burst reset and (if enabled) abort.
module tb_lut_ram_reader;

  localparam int W  = 32;
  localparam int D  = 16384;
  localparam int AW = $clog2(D);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [AW-1:0] ram_read_addr;
  logic [W-1:0]  ram_data;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;
`ifdef LUT_RAM_READER_ABORT_EN
  logic          abort;
`endif

  logic [31:0] ram [D];

  int total;
  int bad;

  lut_ram_reader #(.W(W), .D(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .ram_read_addr (ram_read_addr),
    .ram_data      (ram_data),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .busy          (busy),
    .done          (done)
`ifdef LUT_RAM_READER_ABORT_EN
    ,
    .abort         (abort)
`endif
  );

  assign ram_data = ram[ram_read_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int base;
    int len;
    int stall;
    int inj;
    int exp_n;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: a burst of len words yields ram[(base+i) mod D] for i < min(len, D).
  task automatic run_burst(input int base, input int len, input int stall, input int inj,
                           input int exp_n, input string nm);
    int n;
    int got;
    int cyc;
    int budget;
    logic [31:0] last;
    n = (len > D) ? D : len;
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    length    = (AW + 1)'(len);
    m_ready   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      chk({nm, "_zero_done"}, done, 1);
      chk({nm, "_zero_valid"}, m_valid, 0);
      chk({nm, "_zero_busy"}, busy, 0);
      @(negedge clk);
      chk({nm, "_zero_done_clr"}, done, 0);
      chk({nm, "_zero_valid2"}, m_valid, 0);
      return;
    end
    chk({nm, "_fetch_busy"}, busy, 1);
    chk({nm, "_fetch_valid"}, m_valid, 0);
    got = 0;
    cyc = 0;
    budget = n * 20 + 50;
    last = '0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inj);
      if (cyc == inj) begin
        base_addr = AW'(777);
        length    = (AW + 1)'(3);
      end
      chk({nm, "_done_early"}, done, 0);
      chk({nm, "_valid"}, m_valid, 1);
      m_ready = ($urandom_range(0, 99) >= stall);
      if (m_ready) begin
        last = ram[(base + got) % D];
        chk({nm, "_data"}, m_data, last);
        got++;
      end
    end
    if (got < n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=%0d words required=%0d", nm, got, n);
    end
    @(negedge clk);
    start   = 1'b0;
    m_ready = 1'b0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_valid_clr"}, m_valid, 0);
    chk({nm, "_busy_clr"}, busy, 0);
    chk({nm, "_data_keep"}, m_data, last);
    chk({nm, "_count"}, got, exp_n);
    @(negedge clk);
    chk({nm, "_done_clr"}, done, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    m_ready = 1'b0;
`ifdef LUT_RAM_READER_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < D; i++) ram[i] = $urandom;
    ram[2]   = 32'hDEADBEEF;
    ram[3]   = 32'hCAFEBABE;
    ram[368] = 32'h12345678;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ram_read_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{base: 2,     len: 2,     stall: 0,  inj: -1, exp_n: 2};
    tbl[1] = '{base: 0,     len: 1,     stall: 0,  inj: -1, exp_n: 1};
    tbl[2] = '{base: 100,   len: 5,     stall: 30, inj: -1, exp_n: 5};
    tbl[3] = '{base: 16383, len: 3,     stall: 0,  inj: -1, exp_n: 3};
    tbl[4] = '{base: 16380, len: 10,    stall: 40, inj: -1, exp_n: 10};
    tbl[5] = '{base: 10,    len: 4,     stall: 0,  inj: 1,  exp_n: 4};
    tbl[6] = '{base: 5,     len: 16391, stall: 0,  inj: -1, exp_n: 16384};
    for (int i = 0; i < 7; i++)
      run_burst(tbl[i].base, tbl[i].len, tbl[i].stall, tbl[i].inj, tbl[i].exp_n,
                $sformatf("vec%0d", i));

    run_burst(300, 0, 0, -1, 0, "len0");

    // Backpressure on the first word of the 2-word burst at address 2.
    @(negedge clk);
    start = 1'b1; base_addr = AW'(2); length = (AW + 1)'(2); m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, 32'hDEADBEEF);
      chk("stall_addr", ram_read_addr, 3);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("stall_second", m_data, 32'hCAFEBABE);
    chk("stall_second_valid", m_valid, 1);
    @(negedge clk);
    m_ready = 1'b0;
    chk("stall_done", done, 1);
    chk("stall_busy", busy, 0);
    chk("stall_keep", m_data, 32'hCAFEBABE);
    @(negedge clk);
    chk("stall_done_clr", done, 0);

    // Reset in the middle of a 4-word burst at 368.
    @(negedge clk);
    start = 1'b1; base_addr = AW'(368); length = (AW + 1)'(4); m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_first", m_data, 32'h12345678);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", ram_read_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    run_burst(368, 1, 0, -1, 1, "post_rst");
    chk("post_rst_word", m_data, 32'h12345678);

`ifdef LUT_RAM_READER_ABORT_EN
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_done", done, 0);
    @(negedge clk);
    start = 1'b1; base_addr = AW'(20); length = (AW + 1)'(4); m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    chk("abort_second", m_data, ram[21]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    m_ready = 1'b0;
    chk("abort_valid", m_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    chk("abort_done_clr", done, 0);
`endif

    for (int r = 0; r < 20; r++) begin
      int b;
      int l;
      b = $urandom_range(0, D - 1);
      l = $urandom_range(0, 12);
      run_burst(b, l, $urandom_range(0, 60), -1, l, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
